// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC stream driver and its integration bench.
package mac_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/mac_stream_driver.sv
// Pulls paired A/B operands into the MAC for one dot product of programmable
// length, then presents the captured accumulator on a valid/ready result port.
module mac_stream_driver #(
    parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    vec_len,
    output logic                    busy,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_ready,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    res_valid,
    output logic [3*DATA_WIDTH-1:0] res_data,
    input  logic                    res_ready
);

    import mac_pkg::*;

    state_t                  state;
    state_t                  state_next;
    logic [LEN_WIDTH-1:0]    count;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [3*DATA_WIDTH-1:0] res_q;
    logic                    beat;
    logic                    last_beat;

    // A beat needs both operands; neither stream is popped alone.
    assign beat      = (state == RUN) && a_valid && b_valid;
    assign last_beat = beat && (count == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = (len_q == '0) ? DRAIN : RUN;
            RUN:     if (last_beat) state_next = DRAIN;
            DRAIN:   state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mac_clr   = (state == CLEAR);
        mac_en    = beat;
        a_ready   = beat;
        b_ready   = beat;
        mac_a     = '0;
        mac_b     = '0;
        res_valid = (state == RESULT);
        res_data  = res_q;
        if (state == RUN) begin
            mac_a = a_data;
            mac_b = b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            len_q <= '0;
        end else if (state == IDLE && start) begin
            count <= '0;
            len_q <= vec_len;
        end else if (beat) begin
            count <= count + LEN_WIDTH'(1);
        end
    end

    // Captured in DRAIN, one cycle after the final accumulate edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == DRAIN) begin
            res_q <= mac_cout;
        end
    end

    a_clr_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(mac_clr && mac_en));
    a_ready_paired: assert property (@(posedge clk) disable iff (!rst_n)
        a_ready == b_ready);
    a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (res_valid && !res_ready) |=> $stable(res_data));

endmodule

// File: tb/tb_mac_stream_driver.sv
// Integration bench: driver plus a behavioural MAC, with a result scoreboard.
module tb_mac_stream_driver;

    import mac_pkg::*;

    localparam int LW = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [LW-1:0]         vec_len = '0;
    logic                  busy;
    logic                  a_valid = 1'b0;
    logic [DATA_WIDTH-1:0] a_data = '0;
    logic                  a_ready;
    logic                  b_valid = 1'b0;
    logic [DATA_WIDTH-1:0] b_data = '0;
    logic                  b_ready;
    logic                  mac_en;
    logic                  mac_clr;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [ACC_WIDTH-1:0]  mac_cout;
    logic                  res_valid;
    logic [ACC_WIDTH-1:0]  res_data;
    logic                  res_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [ACC_WIDTH-1:0] exp_q[$];
    int unsigned av[256];
    int unsigned bv[256];

    always #5 clk = ~clk;

    mac_stream_driver #(.DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .busy(busy),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready)
    );

    // Reference MAC: clear beats enable, accumulate on the enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac_cout <= '0;
        else if (mac_clr) mac_cout <= '0;
        else if (mac_en) mac_cout <= mac_cout + ACC_WIDTH'(mac_a) * ACC_WIDTH'(mac_b);
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result handshake is matched against the scoreboard.
    initial begin
        logic [ACC_WIDTH-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL result_unexpected: got %0d, expected none", res_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", longint'(res_data), longint'(e));
                end
            end
        end
    end

    task automatic run_job(input string name, input int len, input bit bubble,
                           input int hold, input int exp_pops);
        int idx = 0;
        int cyc = 1;
        int last = -1;
        int pops = 0;
        int ens = 0;
        int clrs = 0;
        bit done = 1'b0;
        logic [ACC_WIDTH-1:0] sum = '0;
        logic [ACC_WIDTH-1:0] held;
        for (int i = 0; i < len; i++) sum += ACC_WIDTH'(av[i]) * ACC_WIDTH'(bv[i]);
        exp_q.push_back(sum);
        @(negedge clk);
        start = 1'b1;
        vec_len = LW'(len);
        res_ready = 1'b0;
        #1 check({name, "_idle_before"}, longint'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 2000) begin
            a_valid = (idx < len) && (!bubble || (cyc % 2 == 0));
            b_valid = (idx < len);
            a_data  = DATA_WIDTH'(av[idx]);
            b_data  = DATA_WIDTH'(bv[idx]);
            #1;
            if (mac_en) ens++;
            if (mac_clr) clrs++;
            if (a_ready && b_ready) begin
                pops++;
                idx++;
                last = cyc;
            end
            if (res_valid) done = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check({name, "_done"}, longint'(done), 1);
        check({name, "_pops"}, pops, exp_pops);
        check({name, "_mac_en"}, ens, exp_pops);
        check({name, "_mac_clr"}, clrs, 1);
        if (len == 0) check({name, "_start_to_valid"}, cyc, 3);
        else check({name, "_latency"}, cyc - last, 2);
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = 1'b1;
            vec_len = LW'(7);
            #1;
            check({name, "_hold_valid"}, longint'(res_valid), 1);
            check({name, "_hold_data"}, longint'(res_data), longint'(held));
        end
        @(negedge clk);
        res_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        #1 check({name, "_idle_after"}, longint'(busy), 0);
    endtask

    initial begin
        #1;
        check("reset_outputs",
              longint'({busy, a_ready, b_ready, mac_en, mac_clr, res_valid}), 0);
        check("reset_data", longint'({mac_a, mac_b, res_data}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin av[i] = i + 1; bv[i] = i + 5; end
        run_job("basic", 4, 1'b0, 0, 4);

        for (int i = 0; i < 256; i++) begin av[i] = 255; bv[i] = 255; end
        run_job("max3", 3, 1'b0, 0, 3);
        run_job("max255", 255, 1'b0, 0, 255);

        av[0] = 2; av[1] = 3; av[2] = 4;
        bv[0] = 10; bv[1] = 20; bv[2] = 30;
        run_job("bubble", 3, 1'b1, 0, 3);

        run_job("zero", 0, 1'b0, 0, 0);

        av[0] = 7; av[1] = 8; bv[0] = 9; bv[1] = 10;
        run_job("backpressure", 2, 1'b0, 5, 2);
        av[0] = 1; av[1] = 1; bv[0] = 1; bv[1] = 1;
        run_job("no_leak", 2, 1'b0, 0, 2);

        // Abort after two of four beats; nothing is expected from this job.
        for (int i = 0; i < 4; i++) begin av[i] = i + 1; bv[i] = 1; end
        @(negedge clk);
        start = 1'b1;
        vec_len = LW'(4);
        @(negedge clk);
        start = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data = DATA_WIDTH'(av[0]);
        b_data = DATA_WIDTH'(bv[0]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a_data = DATA_WIDTH'(av[k]);
            b_data = DATA_WIDTH'(bv[k]);
            #1 check("abort_beat", longint'(a_ready), 1);
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              longint'({busy, a_ready, b_ready, mac_en, mac_clr, res_valid}), 0);
        check("abort_data", longint'({mac_a, mac_b, res_data}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_idle", longint'(busy), 0);

        av[0] = 3; av[1] = 5; bv[0] = 4; bv[1] = 6;
        run_job("after_reset", 2, 1'b0, 0, 2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_stream_driver.md
Name: mac_stream_driver

Overview:
- Initiator for the multiply-accumulate unit. It pulls paired A/B operand streams over valid/ready and drives the MAC's En/Clr/Ain/Bin inputs.
- Runs one dot product of programmable length, then captures the MAC accumulator and presents it on a valid/ready result port.
- Sits between the operand FIFOs and the MAC instance. It is the only block that drives the MAC control pins.

Parameters:
- DATA_WIDTH, 8, operand width; MAC accumulator and result are 3*DATA_WIDTH.
- LEN_WIDTH, 8, width of the vector-length field. Must be <= DATA_WIDTH so that no accumulation can overflow.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a dot product; sampled only in IDLE
- vec_len  input  LEN_WIDTH  element count; sampled on an accepted start
- busy  output  1  high in any state other than IDLE
- a_valid  input  1  A operand available
- a_data  input  DATA_WIDTH  A operand
- a_ready  output  1  A operand consumed this cycle
- b_valid  input  1  B operand available
- b_data  input  DATA_WIDTH  B operand
- b_ready  output  1  B operand consumed this cycle
- mac_en  output  1  MAC accumulate enable
- mac_clr  output  1  MAC synchronous accumulator clear
- mac_a  output  DATA_WIDTH  MAC Ain
- mac_b  output  DATA_WIDTH  MAC Bin
- mac_cout  input  3*DATA_WIDTH  MAC accumulator value
- res_valid  output  1  result available
- res_data  output  3*DATA_WIDTH  captured dot-product result
- res_ready  input  1  result consumer accepts

Behaviour:
- Reset (async): state=IDLE, elem count=0, len register=0, res_data=0. All outputs low/zero.
- MAC contract:
  - Clr clears the accumulator on the next edge and has priority over En.
  - Product is combinational; accumulate registers on the edge where En=1.
  - Cout reflects a beat one cycle after that beat.
- States: IDLE, CLEAR, RUN, DRAIN, RESULT.
- IDLE:
  - start=1 latches vec_len, count:=0, goes to CLEAR.
  - start is ignored in every other state; busy=1 in those states.
- CLEAR:
  - mac_clr=1 for exactly one cycle, mac_en=0.
  - Goes to DRAIN if len==0, else RUN.
- RUN:
  - Beat fires when a_valid & b_valid. On a beat: mac_en=a_ready=b_ready=1.
  - Never pop one stream without the other.
  - mac_a=a_data and mac_b=b_data combinationally in RUN; zero otherwise.
  - Each beat increments count. The beat with count==len-1 moves to DRAIN.
  - Bubbles (either valid low) hold state with mac_en=0.
- DRAIN:
  - One cycle, mac_en=0, waiting for the final accumulate to land.
  - Goes to RESULT.
- RESULT entry:
  - res_data:=mac_cout, registered on the DRAIN->RESULT edge.
  - res_valid=1 and held stable until res_ready=1.
- RESULT exit:
  - The cycle with res_valid & res_ready returns to IDLE.
  - A start in that same cycle is not accepted; it is accepted from IDLE the following cycle.
- Latency: last beat at cycle t gives res_valid at t+2.
- len==0 gives result 0 (the clear has landed), with no operand pops.
- Width rule:
  - Max sum is (2^LEN_WIDTH-1)*(2^DATA_WIDTH-1)^2, which fits in 3*DATA_WIDTH bits.
  - No saturation logic; the MAC wraps modulo 2^(3*DATA_WIDTH) by construction.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs low.
  - Partially consumed operands are lost. Upstream FIFOs are reset by the same rst_n.
- Assertions:
  - mac_clr and mac_en never both high.
  - a_ready==b_ready always.
  - res_data stable while res_valid & !res_ready.

Decomposition:
- Package mac_pkg:
  - State enum typedef (IDLE, CLEAR, RUN, DRAIN, RESULT).
  - DATA_WIDTH default constant and ACC_WIDTH=3*DATA_WIDTH.
- No sub-module. The counter and FSM are small and live in one module.
- The bench instantiates the existing MAC alongside this block for integration checks.

Test Plan:
- Basic: vec_len=4, A=1,2,3,4, B=5,6,7,8, no bubbles -> exactly 4 pops, res_data=70 at t+2 after the last beat, busy low after handshake.
- Max magnitude: vec_len=3, A=B=255 -> res_data=195075; vec_len=255, A=B=255 -> res_data=16581375 with no wrap.
- Bubbles: vec_len=3, a_valid toggling each cycle, b_valid held high -> pops only on joint valid; mac_en count=3; result matches the golden dot product.
- Zero length: vec_len=0 -> no a_ready/b_ready ever; res_valid with res_data=0 within 3 cycles of start.
- Backpressure: res_ready low for 5 cycles -> res_valid and res_data held stable; start pulses during this time are ignored; the next start after return to IDLE runs correctly and the prior sum does not leak (mac_clr observed).
- Reset mid-RUN after 2 of 4 beats -> all outputs 0 and IDLE next cycle; a new vec_len=2 job (3*4 + 5*6) -> 42.
